// File: rtl/systolic_pkg.sv
// Shared defaults, FSM state type and accumulator clamp bounds for the systolic PE.
package systolic_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } pe_state_e;

    // Bounds come back 64 bits wide; callers truncate them to their accumulator width.
    function automatic logic [63:0] sat_max(int acc_w, bit is_signed);
        logic [63:0] one;
        one = 64'd1;
        if (is_signed) return (one << (acc_w - 1)) - one;
        if (acc_w >= 64) return ~64'd0;
        return (one << acc_w) - one;
    endfunction

    function automatic logic [63:0] sat_min(int acc_w, bit is_signed);
        if (is_signed) return ~64'd0 << (acc_w - 1);
        return 64'd0;
    endfunction

endpackage

// File: rtl/systolic_pe_if.sv
// Operand, result-chain and status bundle of one systolic PE.
interface systolic_pe_if
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    // No backpressure: fire_in qualifies a/w/last for exactly one cycle, and
    // res_valid_in/res_valid_out qualify res_in/res_out while shift_in moves the chain.
    logic              fire_in;
    logic              last_in;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] w_in;
    logic              shift_in;
    logic [ACC_W-1:0]  res_in;
    logic              res_valid_in;
    logic              clr_flags;

    logic              fire_out;
    logic              last_out;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] w_out;
    logic [ACC_W-1:0]  res_out;
    logic              res_valid_out;
    logic              ovf;
    logic              ovr;
    pe_state_e         state_dbg;

    modport slave (
        input  fire_in, last_in, a_in, w_in, shift_in, res_in, res_valid_in, clr_flags,
        output fire_out, last_out, a_out, w_out, res_out, res_valid_out, ovf, ovr, state_dbg
    );

    modport master (
        output fire_in, last_in, a_in, w_in, shift_in, res_in, res_valid_in, clr_flags,
        input  fire_out, last_out, a_out, w_out, res_out, res_valid_out, ovf, ovr, state_dbg
    );
endinterface

// File: rtl/systolic_acc_sat.sv
// Extends a product to accumulator width, adds it, and wraps or clamps on overflow.
module systolic_acc_sat
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic [ACC_W-1:0]    acc,
    input  logic [2*DATA_W-1:0] prod,
    output logic [ACC_W-1:0]    sum,
    output logic                ovf
);
    localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W, SIGNED != 0));
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W, SIGNED != 0));

    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   raw;
    logic             wrap_ovf;

    always_comb begin
        if (SIGNED != 0) ext = ACC_W'($signed(prod));
        else             ext = ACC_W'(prod);
        raw = {1'b0, acc} + {1'b0, ext};
        // Signed overflow: both addends share a sign that the wrapped sum lost.
        if (SIGNED != 0) wrap_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
        else             wrap_ovf = raw[ACC_W];
        sum = raw[ACC_W-1:0];
        if ((SAT != 0) && wrap_ovf) begin
            if ((SIGNED != 0) && acc[ACC_W-1]) sum = MIN_V;
            else                               sum = MAX_V;
        end
        ovf = wrap_ovf;
    end
endmodule

// File: rtl/systolic_pe.sv
// Output-stationary systolic PE: multiply stage, accumulate stage and a shiftable result chain.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic         clk,
    input  logic         rst,
    systolic_pe_if.slave io
);
    localparam int PW = 2 * DATA_W;

    logic              fire_o_q, fire_o_d, last_o_q, last_o_d;
    logic [DATA_W-1:0] a_o_q, a_o_d, w_o_q, w_o_d;
    logic              fire1_q, fire1_d, last1_q, last1_d;
    logic [PW-1:0]     prod1_q, prod1_d;
    logic [ACC_W-1:0]  acc_q, acc_d, res_q, res_d, sum;
    logic              res_vld_q, res_vld_d, ovf_q, ovf_d, ovr_q, ovr_d;
    logic              sum_ovf, complete;
    pe_state_e         state_q, state_d;

    systolic_acc_sat #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED), .SAT(SAT)
    ) u_acc_sat (
        .acc (acc_q),
        .prod(prod1_q),
        .sum (sum),
        .ovf (sum_ovf)
    );

    always_comb begin
        fire_o_d  = io.fire_in;
        last_o_d  = io.last_in;
        a_o_d     = io.a_in;
        w_o_d     = io.w_in;
        fire1_d   = io.fire_in;
        last1_d   = io.fire_in & io.last_in;
        if (SIGNED != 0) prod1_d = PW'($signed(io.a_in)) * PW'($signed(io.w_in));
        else             prod1_d = PW'(io.a_in) * PW'(io.w_in);
        complete  = fire1_q & last1_q;
        acc_d     = acc_q;
        res_d     = res_q;
        res_vld_d = res_vld_q;
        state_d   = state_q;
        if (fire1_q) begin
            if (last1_q) begin
                acc_d     = '0;
                res_d     = sum;
                res_vld_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
        // A completing tile owns res_out; the shifted-in value is dropped that cycle.
        if (io.shift_in && !complete) begin
            res_d     = io.res_in;
            res_vld_d = io.res_valid_in;
        end
        ovf_d = (fire1_q & sum_ovf) | (ovf_q & ~io.clr_flags);
        ovr_d = (complete & res_vld_q & ~io.shift_in) | (ovr_q & ~io.clr_flags);
        case (state_q)
            ST_IDLE: if (fire1_q && !last1_q) state_d = ST_ACC;
            ST_ACC:  if (complete) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fire_o_q  <= 1'b0;
            last_o_q  <= 1'b0;
            a_o_q     <= '0;
            w_o_q     <= '0;
            fire1_q   <= 1'b0;
            last1_q   <= 1'b0;
            prod1_q   <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            ovr_q     <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            fire_o_q  <= fire_o_d;
            last_o_q  <= last_o_d;
            a_o_q     <= a_o_d;
            w_o_q     <= w_o_d;
            fire1_q   <= fire1_d;
            last1_q   <= last1_d;
            prod1_q   <= prod1_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            ovf_q     <= ovf_d;
            ovr_q     <= ovr_d;
            state_q   <= state_d;
        end
    end

    assign io.fire_out      = fire_o_q;
    assign io.last_out      = last_o_q;
    assign io.a_out         = a_o_q;
    assign io.w_out         = w_o_q;
    assign io.res_out       = res_q;
    assign io.res_valid_out = res_vld_q;
    assign io.ovf           = ovf_q;
    assign io.ovr           = ovr_q;
    assign io.state_dbg     = state_q;
endmodule
